// File: rtl/serial_word_deserializer.sv
// Assembles WIDTH-bit words from a qualified serial stream and offers them on a one-word
// valid/ready holding register. Optional trailing even-parity bit: define DESER_PARITY_EN.
module serial_word_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overrun,
  output logic             parity_err
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef DESER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             complete;
  logic [WIDTH-1:0] done_word;
`ifdef DESER_PARITY_EN
  logic             perr_q, perr_d;
  logic             done_perr;
`endif

  // A frame_start bit always lands at index 0 of an empty word, whatever the state.
  logic [CW-1:0]    eff_cnt, bit_pos;
  logic [WIDTH-1:0] ins_mask, base_word, ins_word;

  assign eff_cnt   = frame_start ? '0 : cnt_q;
  assign bit_pos   = MSB_FIRST ? (LAST - eff_cnt) : eff_cnt;
  assign base_word = frame_start ? '0 : shreg_q;

  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_ins_mask
    assign ins_mask[gi] = (bit_pos == CW'(gi));
  end

  assign ins_word = (base_word & ~ins_mask) | (ins_mask & {WIDTH{serial_in}});

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    word_d    = word_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    complete  = 1'b0;
    done_word = shreg_q;
`ifdef DESER_PARITY_EN
    perr_d    = perr_q;
    done_perr = 1'b0;
`endif

    if (bit_valid) begin
      if (frame_start) begin
        shreg_d = ins_word;
        cnt_d   = CW'(1);
        state_d = SHIFT;
      end else begin
        case (state_q)
          SHIFT: begin
            shreg_d = ins_word;
            if (cnt_q == LAST) begin
`ifdef DESER_PARITY_EN
              state_d = PARITY;
`else
              complete  = 1'b1;
              done_word = ins_word;
              cnt_d     = '0;
              state_d   = IDLE;
`endif
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
`ifdef DESER_PARITY_EN
          PARITY: begin
            complete  = 1'b1;
            done_word = shreg_q;
            done_perr = ^{shreg_q, serial_in};
            cnt_d     = '0;
            state_d   = IDLE;
          end
`endif
          default: ;
        endcase
      end
    end

    // Holding register: a completion only lands if the slot is free or being drained.
    if (complete) begin
      if (!valid_q || word_ready) begin
        word_d  = done_word;
        valid_d = 1'b1;
`ifdef DESER_PARITY_EN
        perr_d  = done_perr;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef DESER_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
`ifdef DESER_PARITY_EN
      perr_q    <= perr_d;
`endif
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign overrun    = overrun_q;
`ifdef DESER_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Bench for serial_word_deserializer: directed scenarios plus a randomized run against a
// bit-list reference model; a second instance runs MSB_FIRST=1 on the same stimulus.
module tb_serial_word_deserializer;
  localparam int W = 8;
`ifdef DESER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         serial_in = 1'b0;
  logic         bit_valid = 1'b0;
  logic         frame_start = 1'b0;
  logic         word_ready = 1'b0;
  logic [W-1:0] word_out, m_word_out;
  logic         word_valid, m_word_valid;
  logic         overrun, m_overrun;
  logic         parity_err, m_parity_err;

  int total = 0;
  int bad = 0;
  int hs_count = 0;
  int ov_count = 0;
  logic [W-1:0] hs_word = '0;

  // reference model state for the randomized run
  logic         in_frame;
  logic         bits[$];
  logic         mv, movr, mp;
  logic [W-1:0] mw;

  always #5 clk = ~clk;

  serial_word_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .word_out(word_out), .word_valid(word_valid),
    .word_ready(word_ready), .overrun(overrun), .parity_err(parity_err)
  );

  serial_word_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .word_out(m_word_out), .word_valid(m_word_valid),
    .word_ready(word_ready), .overrun(m_overrun), .parity_err(m_parity_err)
  );

  always @(posedge clk) begin
    if (!rst && word_valid && word_ready) begin
      hs_count <= hs_count + 1;
      hs_word  <= word_out;
      $display("[%0t] word accepted 0x%02h parity_err=%0b", $time, word_out, parity_err);
    end
    if (!rst && overrun) ov_count <= ov_count + 1;
  end

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  task automatic drive(input logic bv, input logic fs, input logic sin, input logic rdy);
    rst = 1'b0; bit_valid = bv; frame_start = fs; serial_in = sin; word_ready = rdy;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic pbit, input int gap,
                            input logic rdy);
    for (int i = 0; i < NB; i++) begin
      drive(1'b1, i == 0, (i < W) ? w[i] : pbit, rdy);
      if (i < NB - 1) for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 1'b0, rdy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bit_valid = 1'b1; frame_start = 1'b1; serial_in = 1'b1; word_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    total++;
    if ({word_out, word_valid, overrun, parity_err} !== '0) begin
      bad++; $display("FAIL reset_outputs: got out=%h v=%b ov=%b pe=%b, need all 0",
                      word_out, word_valid, overrun, parity_err);
    end
    total++;
    if ({m_word_out, m_word_valid, m_overrun, m_parity_err} !== '0) begin
      bad++; $display("FAIL reset_outputs_msb: got out=%h v=%b, need all 0",
                      m_word_out, m_word_valid);
    end
  endtask

  task automatic test_basic();
    int hs0 = hs_count;
    send_frame(8'hA5, ~^8'hA5, 0, 1'b1);
    total++;
    if (word_valid !== 1'b1 || word_out !== 8'hA5) begin
      bad++; $display("FAIL basic_word: got v=%b out=%h, need v=1 out=a5", word_valid, word_out);
    end
    total++;
    if (m_word_out !== rev(8'hA5)) begin
      bad++; $display("FAIL basic_msb: got %h, need %h", m_word_out, rev(8'hA5));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (word_valid !== 1'b0 || hs_count - hs0 != 1) begin
      bad++; $display("FAIL basic_drain: got v=%b hs=%0d, need v=0 hs=1",
                      word_valid, hs_count - hs0);
    end
  endtask

  task automatic test_gaps();
    int hs0 = hs_count;
    send_frame(8'hA5, ~^8'hA5, 3, 1'b1);
    repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (hs_count - hs0 != 1 || hs_word !== 8'hA5) begin
      bad++; $display("FAIL gaps_once: got hs=%0d word=%h, need hs=1 word=a5",
                      hs_count - hs0, hs_word);
    end
  endtask

  task automatic test_overrun();
    int ov0 = ov_count;
    send_frame(8'h3C, ~^8'h3C, 0, 1'b0);
    send_frame(8'hFF, ~^8'hFF, 0, 1'b0);
    total++;
    if (overrun !== 1'b1 || word_out !== 8'h3C || word_valid !== 1'b1) begin
      bad++; $display("FAIL overrun_pulse: got ov=%b out=%h v=%b, need ov=1 out=3c v=1",
                      overrun, word_out, word_valid);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (overrun !== 1'b0 || word_valid !== 1'b1 || ov_count - ov0 != 1) begin
      bad++; $display("FAIL overrun_single: got ov=%b v=%b pulses=%0d, need ov=0 v=1 pulses=1",
                      overrun, word_valid, ov_count - ov0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (word_valid !== 1'b0) begin
      bad++; $display("FAIL overrun_drain: got v=%b, need 0", word_valid);
    end
  endtask

  task automatic test_restart();
    int hs0 = hs_count;
    int ov0 = ov_count;
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
    send_frame(8'h81, ~^8'h81, 0, 1'b1);
    total++;
    if (word_out !== 8'h81 || m_word_out !== rev(8'h81) || word_valid !== 1'b1) begin
      bad++; $display("FAIL restart_word: got %h/%h v=%b, need 81/%h v=1",
                      word_out, m_word_out, word_valid, rev(8'h81));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (hs_count - hs0 != 1 || ov_count - ov0 != 0) begin
      bad++; $display("FAIL restart_count: got hs=%0d ov=%0d, need hs=1 ov=0",
                      hs_count - hs0, ov_count - ov0);
    end
  endtask

  task automatic test_reset_mid();
    int hs0;
    send_frame(8'h3C, ~^8'h3C, 0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 1'b0);
    rst = 1'b1; @(posedge clk); #1;
    total++;
    if ({word_out, word_valid, overrun, parity_err} !== '0) begin
      bad++; $display("FAIL midreset_outputs: got out=%h v=%b, need 0", word_out, word_valid);
    end
    hs0 = hs_count;
    for (int i = 0; i < NB; i++) drive(1'b1, 1'b0, 1'b1, 1'b1);
    total++;
    if (word_valid !== 1'b0) begin
      bad++; $display("FAIL midreset_idle: got v=%b, need 0 (no frame_start)", word_valid);
    end
    send_frame(8'h5A, ~^8'h5A, 0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (hs_count - hs0 != 1 || hs_word !== 8'h5A) begin
      bad++; $display("FAIL midreset_word: got hs=%0d word=%h, need hs=1 word=5a",
                      hs_count - hs0, hs_word);
    end
  endtask

  task automatic test_parity();
    logic exp_bad;
`ifdef DESER_PARITY_EN
    exp_bad = 1'b1;
`else
    exp_bad = 1'b0;
`endif
    send_frame(8'h07, 1'b1, 0, 1'b1);
    total++;
    if (word_valid !== 1'b1 || parity_err !== 1'b0) begin
      bad++; $display("FAIL parity_good: got v=%b pe=%b, need v=1 pe=0", word_valid, parity_err);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h07, 1'b0, 0, 1'b1);
    total++;
    if (word_valid !== 1'b1 || parity_err !== exp_bad) begin
      bad++; $display("FAIL parity_bad: got v=%b pe=%b, need v=1 pe=%b",
                      word_valid, parity_err, exp_bad);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic bv, fs, sin, rdy, done;
    logic [W-1:0] nw;
    logic np;
    rst = 1'b1; @(posedge clk); #1;
    in_frame = 1'b0; bits.delete(); mv = 1'b0; mw = '0; mp = 1'b0; movr = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      bv  = ($urandom_range(0, 9) < 7);
      fs  = ($urandom_range(0, 15) == 0);
      sin = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 2) != 0);
      drive(bv, fs, sin, rdy);
      done = 1'b0; movr = 1'b0; nw = '0; np = 1'b0;
      if (bv) begin
        if (fs) begin
          bits.delete(); bits.push_back(sin); in_frame = 1'b1;
        end else if (in_frame) begin
          bits.push_back(sin);
        end
        if (in_frame && bits.size() == NB) begin
          done = 1'b1; in_frame = 1'b0;
          for (int i = 0; i < W; i++) nw[i] = bits[i];
          np = ^nw;
          if (NB > W) np = np ^ bits[NB-1];
          else np = 1'b0;
        end
      end
      if (done) begin
        if (!mv || rdy) begin mv = 1'b1; mw = nw; mp = np; end
        else movr = 1'b1;
      end else if (mv && rdy) begin
        mv = 1'b0;
      end
      total++;
      if (word_valid !== mv || m_word_valid !== mv) begin
        bad++; $display("FAIL rand_valid c=%0d: got %b/%b, need %b", c, word_valid, m_word_valid, mv);
      end
      total++;
      if (overrun !== movr || m_overrun !== movr) begin
        bad++; $display("FAIL rand_overrun c=%0d: got %b/%b, need %b", c, overrun, m_overrun, movr);
      end
      if (mv) begin
        total++;
        if (word_out !== mw || m_word_out !== rev(mw)) begin
          bad++; $display("FAIL rand_word c=%0d: got %h/%h, need %h/%h",
                          c, word_out, m_word_out, mw, rev(mw));
        end
        total++;
        if (parity_err !== mp || m_parity_err !== mp) begin
          bad++; $display("FAIL rand_parity c=%0d: got %b/%b, need %b",
                          c, parity_err, m_parity_err, mp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overrun();
    test_restart();
    test_reset_mid();
    test_parity();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
